// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register map and delivery FSM encoding for irq_ctrl
package irq_ctrl_pkg;

  localparam logic [2:0] REG_ENABLE  = 3'd0;
  localparam logic [2:0] REG_EDGE    = 3'd1;
  localparam logic [2:0] REG_PENDING = 3'd2;
  localparam logic [2:0] REG_FORCE   = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_TIMER   = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELIVER = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-set-bit priority encoder, 32 inputs to 5-bit id
module irq_prio_enc (
  input  logic [31:0] vec_i,
  output logic [4:0]  id_o,
  output logic        valid_o
);

  always_comb begin
    id_o    = 5'd0;
    valid_o = |vec_i;
    for (int i = 31; i >= 0; i--) begin
      if (vec_i[i]) id_o = 5'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller: sync/latch sources, deliver irq, retire on eoi
// Optional down-counter timer source enabled by defining IRQ_CTRL_TIMER_EN.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_SRC        = 32,
  parameter int          SYNC_STAGES    = 2,
  parameter int          HOLDOFF_CYCLES = 4,
  parameter logic [31:0] EDGE_RESET     = 32'hffff_ffff,
  parameter int          TIMER_SRC      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] src,
  input  logic [31:0] eoi,
  output logic [31:0] irq,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        active_valid,
  output logic [4:0]  active_id
);

  localparam logic [31:0] SRC_MASK  = (NUM_SRC >= 32) ? 32'hffff_ffff
                                                      : ((32'd1 << NUM_SRC) - 32'd1);
  localparam logic [31:0] TIMER_BIT = 32'd1 << TIMER_SRC;
  localparam int          CNT_W     = $clog2(HOLDOFF_CYCLES + 2);

  logic [SYNC_STAGES-1:0][31:0] sync_q;
  logic [31:0] prev_q;
  logic [31:0] enable_q, enable_d;
  logic [31:0] edge_q, edge_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  irq_state_e  state_q, state_d;
  logic        act_valid_q;
  logic [4:0]  act_id_q;
  logic        enc_valid;
  logic [4:0]  enc_id;

  logic [31:0] sync_lvl, rise, set_vec, clr_vec, retire, edge_eff;
  logic [31:0] force_set, w1c, timer_rd;
  logic        timer_fire;

  assign sync_lvl  = sync_q[SYNC_STAGES-1];
  assign rise      = sync_lvl & ~prev_q;
  assign force_set = (cfg_wr && cfg_addr == REG_FORCE) ? cfg_wdata : 32'h0;
  assign w1c       = (cfg_wr && cfg_addr == REG_PENDING) ? cfg_wdata : 32'h0;

`ifdef IRQ_CTRL_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
  logic [31:0] timer_q, timer_d;

  always_comb begin
    timer_d    = timer_q;
    timer_fire = 1'b0;
    if (cfg_wr && cfg_addr == REG_TIMER) begin
      timer_d = cfg_wdata;
    end else if (timer_q != 32'h0) begin
      timer_d    = timer_q - 32'd1;
      timer_fire = (timer_q == 32'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= 32'h0;
    else       timer_q <= timer_d;
  end

  assign timer_rd = timer_q;
`else
  localparam bit TIMER_EN = 1'b0;
  assign timer_fire = 1'b0;
  assign timer_rd   = 32'h0;
`endif

  // The timer bit must latch like an edge source even when EDGE marks it level.
  assign edge_eff = edge_q | (TIMER_EN ? TIMER_BIT : 32'h0);
  assign retire   = (state_q == DELIVER) ? (eoi & irq_q) : 32'h0;
  assign set_vec  = (edge_q & rise) | (~edge_q & sync_lvl) | force_set
                  | (timer_fire ? TIMER_BIT : 32'h0);
  assign clr_vec  = w1c | (retire & edge_eff);

  always_comb begin
    enable_d  = enable_q;
    edge_d    = edge_q;
    if (cfg_wr && cfg_addr == REG_ENABLE) enable_d = cfg_wdata & SRC_MASK;
    if (cfg_wr && cfg_addr == REG_EDGE)   edge_d   = cfg_wdata & SRC_MASK;
    pending_d = (set_vec | (pending_q & ~clr_vec & edge_eff)) & SRC_MASK;
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if ((pending_q & enable_q) != 32'h0) begin
          irq_d   = pending_q & enable_q;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        irq_d = irq_q & ~eoi;
        if (irq_d == 32'h0) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end
      end
      HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) state_d = IDLE;
        else                                     cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (cfg_rd) begin
      case (cfg_addr)
        REG_ENABLE:  rdata_d = enable_q;
        REG_EDGE:    rdata_d = edge_q;
        REG_PENDING: rdata_d = pending_q;
        REG_STATUS:  rdata_d = {26'h0, act_valid_q, act_id_q};
        REG_TIMER:   rdata_d = timer_rd;
        default:     rdata_d = 32'h0;
      endcase
    end
  end

  irq_prio_enc u_enc (
    .vec_i   (irq_d),
    .id_o    (enc_id),
    .valid_o (enc_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      prev_q      <= 32'h0;
      enable_q    <= 32'h0;
      edge_q      <= EDGE_RESET & SRC_MASK;
      pending_q   <= 32'h0;
      irq_q       <= 32'h0;
      rdata_q     <= 32'h0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      act_valid_q <= 1'b0;
      act_id_q    <= 5'd0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], src & SRC_MASK};
      prev_q      <= sync_lvl;
      enable_q    <= enable_d;
      edge_q      <= edge_d;
      pending_q   <= pending_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      act_valid_q <= enc_valid;
      act_id_q    <= enc_id;
    end
  end

  assign irq          = irq_q;
  assign cfg_rdata    = rdata_q;
  assign active_valid = act_valid_q;
  assign active_id    = act_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl delivery, registers and timer
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src, eoi, cfg_wdata;
  logic        cfg_wr, cfg_rd;
  logic [2:0]  cfg_addr;
  logic [31:0] irq, cfg_rdata;
  logic        active_valid;
  logic [4:0]  active_id;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v, obs;

  irq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .src          (src),
    .eoi          (eoi),
    .irq          (irq),
    .cfg_wr       (cfg_wr),
    .cfg_rd       (cfg_rd),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .active_valid (active_valid),
    .active_id    (active_id)
  );

  always #5 clk = ~clk;

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
    cfg_addr = a; cfg_rd = 1'b1;
    @(negedge clk);
    cfg_rd = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic test_reset;
    logic [2:0] addrs [3];
    reset = 1'b1; src = '0; eoi = '0; cfg_wr = 1'b0; cfg_rd = 1'b0;
    cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_irq got=%h exp=%h", obs, exp_v); end
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); obs = {26'h0, active_valid, active_id}; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_active got=%h exp=%h", obs, exp_v); end
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); obs = cfg_rdata; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_rdata got=%h exp=%h", obs, exp_v); end
    addrs = '{REG_ENABLE, REG_EDGE, REG_PENDING};
    exp_q.push_back(32'h0); exp_q.push_back(32'hffff_ffff); exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      cfg_read(addrs[i], obs);
      exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_reg%0d got=%h exp=%h", addrs[i], obs, exp_v); end
    end
  endtask

  task automatic test_edge_delivery;
    cfg_write(REG_ENABLE, 32'hffff_ffff);
    src = 32'h8;
    for (int c = 1; c <= 4; c++) begin
      exp_q.push_back(c == 4 ? 32'h8 : 32'h0);
      @(negedge clk);
      src = '0;
      exp_v = exp_q.pop_front(); obs = irq; n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL edge_latency c=%0d got=%h exp=%h", c, obs, exp_v); end
    end
    exp_q.push_back(32'h23);
    exp_v = exp_q.pop_front(); obs = {26'h0, active_valid, active_id}; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL edge_active_id got=%h exp=%h", obs, exp_v); end
    eoi = 32'h8;
    exp_q.push_back(32'h0);
    @(negedge clk);
    eoi = '0;
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL edge_retire got=%h exp=%h", obs, exp_v); end
    exp_q.push_back(32'h0);
    cfg_read(REG_PENDING, obs);
    exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL edge_pending_clr got=%h exp=%h", obs, exp_v); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_level_redelivery;
    cfg_write(REG_EDGE, 32'h0);
    src = 32'h20;
    for (int k = 0; k < 20 && irq !== 32'h20; k++) @(negedge clk);
    exp_q.push_back(32'h20);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL level_first got=%h exp=%h", obs, exp_v); end
    eoi = 32'h20;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(c == 6 ? 32'h20 : 32'h0);
      @(negedge clk);
      eoi = '0;
      exp_v = exp_q.pop_front(); obs = irq; n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL level_holdoff c=%0d got=%h exp=%h", c, obs, exp_v); end
    end
    src = '0; eoi = 32'h20;
    @(negedge clk);
    eoi = '0;
    repeat (12) @(negedge clk);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL level_dropped_irq got=%h exp=%h", obs, exp_v); end
    exp_q.push_back(32'h0);
    cfg_read(REG_PENDING, obs);
    exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL level_dropped_pend got=%h exp=%h", obs, exp_v); end
    cfg_write(REG_EDGE, 32'hffff_ffff);
  endtask

  task automatic test_snapshot;
    cfg_write(REG_FORCE, 32'h1);
    for (int k = 0; k < 10 && irq !== 32'h1; k++) @(negedge clk);
    src = 32'h4;
    @(negedge clk);
    src = '0;
    repeat (6) @(negedge clk);
    exp_q.push_back(32'h1);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL snapshot_hold got=%h exp=%h", obs, exp_v); end
    exp_q.push_back(32'h5);
    cfg_read(REG_PENDING, obs);
    exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL snapshot_pending got=%h exp=%h", obs, exp_v); end
    eoi = 32'h1;
    @(negedge clk);
    eoi = '0;
    for (int k = 0; k < 12 && irq === 32'h0; k++) @(negedge clk);
    exp_q.push_back(32'h4);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL snapshot_next got=%h exp=%h", obs, exp_v); end
    eoi = 32'h4;
    @(negedge clk);
    eoi = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_set_priority;
    cfg_write(REG_FORCE, 32'h10);
    for (int k = 0; k < 10 && irq !== 32'h10; k++) @(negedge clk);
    cfg_addr = REG_FORCE; cfg_wdata = 32'h10; cfg_wr = 1'b1; eoi = 32'h10;
    exp_q.push_back(32'h0);
    @(negedge clk);
    cfg_wr = 1'b0; eoi = '0;
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL prio_retire got=%h exp=%h", obs, exp_v); end
    exp_q.push_back(32'h10);
    cfg_read(REG_PENDING, obs);
    exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL prio_pending got=%h exp=%h", obs, exp_v); end
    for (int k = 0; k < 12 && irq !== 32'h10; k++) @(negedge clk);
    exp_q.push_back(32'h10);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL prio_redeliver got=%h exp=%h", obs, exp_v); end
    eoi = 32'h10;
    @(negedge clk);
    eoi = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_w1c_regs;
    logic [2:0] addrs [3];
    cfg_write(REG_ENABLE, 32'h0);
    cfg_write(REG_FORCE, 32'hF0);
    cfg_write(REG_PENDING, 32'h30);
    exp_q.push_back(32'hC0);
    cfg_read(REG_PENDING, obs);
    exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL w1c_pending got=%h exp=%h", obs, exp_v); end
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL w1c_masked_irq got=%h exp=%h", obs, exp_v); end
    cfg_write(REG_PENDING, 32'hC0);
    cfg_write(3'd6, 32'hdead_beef);
    cfg_write(3'd5, 32'h0);
    addrs = '{3'd6, REG_FORCE, REG_PENDING};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0);
      cfg_read(addrs[i], obs);
      exp_v = exp_q.pop_front(); n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL zero_read_reg%0d got=%h exp=%h", addrs[i], obs, exp_v); end
    end
`ifndef IRQ_CTRL_TIMER_EN
    cfg_write(REG_TIMER, 32'h55);
    exp_q.push_back(32'h0);
    cfg_read(REG_TIMER, obs);
    exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL timer_absent got=%h exp=%h", obs, exp_v); end
`endif
  endtask

  task automatic test_reset_mid_deliver;
    cfg_write(REG_ENABLE, 32'hffff_ffff);
    cfg_write(REG_FORCE, 32'h2);
    for (int k = 0; k < 10 && irq !== 32'h2; k++) @(negedge clk);
    exp_q.push_back(32'h2);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_deliver got=%h exp=%h", obs, exp_v); end
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL async_reset_irq got=%h exp=%h", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = {26'h0, active_valid, active_id}; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL async_reset_active got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'h0);
    cfg_read(REG_ENABLE, obs);
    exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL async_reset_enable got=%h exp=%h", obs, exp_v); end
  endtask

`ifdef IRQ_CTRL_TIMER_EN
  task automatic test_timer;
    cfg_write(REG_ENABLE, 32'h1);
    cfg_write(REG_TIMER, 32'd10);
    for (int c = 2; c <= 12; c++) begin
      exp_q.push_back(c == 12 ? 32'h1 : 32'h0);
      @(negedge clk);
      exp_v = exp_q.pop_front(); obs = irq; n_tests++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL timer_fire c=%0d got=%h exp=%h", c, obs, exp_v); end
    end
    eoi = 32'h1;
    @(negedge clk);
    eoi = '0;
    repeat (8) @(negedge clk);
    cfg_write(REG_TIMER, 32'd20);
    exp_q.push_back(32'd20);
    cfg_read(REG_TIMER, obs);
    exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL timer_read got=%h exp=%h", obs, exp_v); end
    repeat (3) @(negedge clk);
    cfg_write(REG_TIMER, 32'd0);
    repeat (30) @(negedge clk);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); obs = irq; n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL timer_stop_irq got=%h exp=%h", obs, exp_v); end
    cfg_read(REG_PENDING, obs);
    exp_v = exp_q.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL timer_stop_pend got=%h exp=%h", obs, exp_v); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_edge_delivery();
    test_level_redelivery();
    test_snapshot();
    test_set_priority();
    test_w1c_regs();
    test_reset_mid_deliver();
`ifdef IRQ_CTRL_TIMER_EN
    test_timer();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Peripheral-side interrupt controller that drives the CPU core's 32-bit irq input and consumes its eoi vector.
- Synchronises and latches up to 32 external sources; applies a software enable mask.
- Presents irq to the core through a delivery state machine and retires bits when eoi returns.
- Simple register port lets firmware configure, inspect and force interrupts.
- Sits between peripherals and the core, one level up from the core's IRQ logic.

Parameters:
- NUM_SRC, 32, number of implemented sources; bits >= NUM_SRC read 0 and never assert.
- SYNC_STAGES, 2, synchroniser flops per source input (>=2).
- HOLDOFF_CYCLES, 4, idle cycles forced after all delivered bits retire, before re-delivery.
- EDGE_RESET, 32'hffff_ffff, reset value of EDGE register (1 = rising-edge latched, 0 = level).
- TIMER_SRC, 0, source index driven by the optional timer.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- src  in  32  raw asynchronous interrupt sources.
- eoi  in  32  end-of-interrupt vector from core; level, sampled every cycle.
- irq  out  32  interrupt vector to core; registered.
- cfg_wr  in  1  register write strobe, single cycle.
- cfg_rd  in  1  register read strobe.
- cfg_addr  in  3  register index.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  read data, valid the cycle after cfg_rd.
- active_valid  out  1  high while any bit of irq is set.
- active_id  out  5  lowest-numbered set bit of irq; 0 when none.

Behaviour:
- Reset: irq=0, cfg_rdata=0, active_valid=0, active_id=0, PENDING=0, ENABLE=0, EDGE=EDGE_RESET, FSM=IDLE, synchronisers cleared.
- Registers: 0 ENABLE rw; 1 EDGE rw; 2 PENDING r, write-1-clear; 3 FORCE w, write-1-set into PENDING, reads 0; 4 STATUS r = {26'b0, active_valid, active_id}; 5 TIMER (optional feature only); 6-7 read 0, writes ignored.
- Source path: src[i] passes SYNC_STAGES flops. Edge source sets PENDING[i] on a synchronised 0->1 transition. For a level source, PENDING[i] tracks the synchronised level every cycle, so W1C has no lasting effect while the level stays high.
- Set priority: on the same cycle, a set event (edge, level, FORCE) beats any clear (eoi, W1C).
- FSM IDLE: when (PENDING & ENABLE) != 0, irq <= PENDING & ENABLE; go to DELIVER. Latency: a synchronised edge reaches irq 2 cycles later (PENDING, then irq).
- FSM DELIVER:
  - irq bits are held; no new bits are added while in DELIVER.
  - Every cycle, r = eoi & irq. Edge bits in r clear PENDING; every bit in r clears irq.
  - eoi bits not set in irq are ignored.
  - When irq becomes 0, go to HOLDOFF.
- FSM HOLDOFF: count HOLDOFF_CYCLES cycles, then go to IDLE. A level source still high re-delivers from IDLE.
- ENABLE cleared during DELIVER: irq is not revoked; the bit retires normally via eoi.
- active_id comes from a combinational lowest-index priority encoder on irq, registered with irq.
- Reset mid-DELIVER clears everything immediately, because reset is asynchronous.

Optional Feature:
- Macro: IRQ_CTRL_TIMER_EN.
- With it:
  - TIMER register (addr 5) is a 32-bit down-counter; writing loads it, reading returns the current count.
  - A nonzero value decrements every cycle.
  - The 1->0 transition sets PENDING[TIMER_SRC], which is treated as an edge source regardless of EDGE.
  - src[TIMER_SRC] is still ORed in through its own path.
  - Writing 0 stops the timer without raising an interrupt.
- Without it: addr 5 reads 0, writes are ignored, no counter logic.

Decomposition:
- Package irq_ctrl_pkg: register index constants (REG_ENABLE..REG_TIMER) and the FSM state enum (IDLE, DELIVER, HOLDOFF) with 2-bit encoding.
- Sub-module irq_prio_enc: 32-bit lowest-set-bit encoder giving a 5-bit id and a valid flag. It is reused by the core-side debug logic.

Test Plan:
- Edge delivery: ENABLE=1, EDGE[3]=1, pulse src[3] for 1 cycle -> irq=32'h8 at sync+2 cycles, active_id=3. Assert eoi[3] -> irq=0 next cycle, PENDING=0, then HOLDOFF of 4 cycles.
- Level re-delivery: EDGE=0, hold src[5] high, retire via eoi[5] -> irq[5] reasserts exactly HOLDOFF_CYCLES+1 cycles after retire. Drop src[5] -> PENDING[5]=0, no further irq.
- Snapshot rule: in DELIVER with irq=32'h1, pulse src[2] -> irq stays 32'h1. After eoi[0] and holdoff, irq=32'h4.
- Set priority: FORCE write 32'h10 on the same cycle as eoi[4] with irq[4] set -> PENDING[4]=1 and it re-delivers.
- W1C and reset: PENDING=32'hF0, write 32'h30 to addr 2 -> read 32'hC0. Assert reset mid-DELIVER -> irq=0, ENABLE=0 asynchronously.
- Timer (IRQ_CTRL_TIMER_EN): write TIMER=10, ENABLE[0]=1 -> PENDING[0] is set 10 cycles later. Write TIMER=0 mid-count -> no interrupt.
